// File: rtl/instr_ctrl_pkg.sv
// Shared opcode and micro-phase definitions for the instruction controller.
// Every instruction occupies one full upc cycle: fetch, operand, store, PC update.
package instr_ctrl_pkg;

   typedef enum logic [2:0] {
      OP_HLT = 3'b000,
      OP_SKZ = 3'b001,
      OP_ADD = 3'b010,
      OP_AND = 3'b011,
      OP_XOR = 3'b100,
      OP_LDA = 3'b101,
      OP_STO = 3'b110,
      OP_JMP = 3'b111
   } opcode_t;

   localparam logic [1:0] PH_FETCH = 2'h0;
   localparam logic [1:0] PH_OPND  = 2'h1;
   localparam logic [1:0] PH_STORE = 2'h2;
   localparam logic [1:0] PH_PCUPD = 2'h3;

   // Opcodes that need the operand from memory during the operand phase.
   function automatic logic reads_operand(input opcode_t op);
      logic r;
      case (op)
         OP_ADD, OP_AND, OP_XOR, OP_LDA: r = 1'b1;
         default:                        r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/instr_alu.sv
// Next-accumulator datapath: combines acc with memory data according to opcode.
// Purely combinational; opcodes that do not touch acc pass it through unchanged.
module instr_alu
   import instr_ctrl_pkg::*;
(
   input  logic [7:0] acc,
   input  logic [7:0] data,
   input  logic [2:0] opcode,
   output logic [7:0] result
);

   always_comb begin
      result = acc;
      case (opcode_t'(opcode))
         OP_ADD:  result = acc + data;
         OP_AND:  result = acc & data;
         OP_XOR:  result = acc ^ data;
         OP_LDA:  result = data;
         default: result = acc;
      endcase
   end

endmodule

// File: rtl/instr_ctrl.sv
// Fetch/decode/execute controller driven by the program counter's pc and upc phase.
// Holds ir, acc and a sticky halt flag; address mux and strobes are combinational on upc.
module instr_ctrl
   import instr_ctrl_pkg::*;
#(
   parameter logic [2:0] PAGE = 3'b000
)
(
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] pc,
   input  logic [1:0] upc,
   input  logic [7:0] mem_rdata,
   output logic [7:0] mem_addr,
   output logic       mem_rd,
   output logic       mem_wr,
   output logic [7:0] mem_wdata,
   output logic       pc_load,
   output logic [7:0] pc_addr,
   output logic [7:0] ir,
   output logic [7:0] acc,
   output logic       zero,
   output logic       halted
);

   opcode_t    op;
   logic [7:0] opa;
   logic [7:0] alu_result;

   assign op        = opcode_t'(ir[7:5]);
   assign opa       = {PAGE, ir[4:0]};
   assign zero      = (acc == 8'h00);
   assign mem_wdata = acc;

   instr_alu u_alu (
      .acc    (acc),
      .data   (mem_rdata),
      .opcode (ir[7:5]),
      .result (alu_result)
   );

   // Once halted nothing but reset may change architectural state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ir     <= 8'h00;
         acc    <= 8'h00;
         halted <= 1'b0;
      end else if (!halted) begin
         if (upc == PH_FETCH)
            ir <= mem_rdata;
         if (upc == PH_OPND) begin
            acc <= alu_result;
            if (op == OP_HLT)
               halted <= 1'b1;
         end
      end
   end

   always_comb begin
      mem_addr = pc;
      mem_rd   = 1'b0;
      mem_wr   = 1'b0;
      pc_load  = 1'b0;
      pc_addr  = pc;
      case (upc)
         PH_FETCH: begin
            mem_rd = !halted;
         end
         PH_OPND: begin
            mem_addr = opa;
            mem_rd   = !halted && reads_operand(op);
         end
         PH_STORE: begin
            if (op == OP_STO) begin
               mem_addr = opa;
               mem_wr   = !halted;
            end
         end
         PH_PCUPD: begin
            // Reloading pc with itself is how a halt freezes the upstream counter.
            if (halted || op == OP_HLT) begin
               pc_load = 1'b1;
            end else if (op == OP_JMP) begin
               pc_load = 1'b1;
               pc_addr = opa;
            end else if (op == OP_SKZ && zero) begin
               pc_load = 1'b1;
               pc_addr = pc + 8'd2;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_instr_ctrl.sv
// Bench for instr_ctrl: the bench plays program counter and asynchronous memory,
// expected per-phase outputs are queued per instruction and compared as each phase is driven.
module tb_instr_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] pc;
   logic [1:0] upc;
   logic [7:0] mem_rdata;
   logic [7:0] mem_addr;
   logic       mem_rd;
   logic       mem_wr;
   logic [7:0] mem_wdata;
   logic       pc_load;
   logic [7:0] pc_addr;
   logic [7:0] ir;
   logic [7:0] acc;
   logic       zero;
   logic       halted;

   logic [7:0] mem [256];

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [7:0] addr;
      logic       rd;
      logic       wr;
      logic [7:0] wdata;
      logic       pl;
      logic [7:0] pa;
      logic [7:0] ir;
      logic [7:0] acc;
      logic       zero;
      logic       halted;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   assign mem_rdata = mem[mem_addr];

   instr_ctrl #(.PAGE(3'b000)) dut (
      .clk       (clk),
      .rst       (rst),
      .pc        (pc),
      .upc       (upc),
      .mem_rdata (mem_rdata),
      .mem_addr  (mem_addr),
      .mem_rd    (mem_rd),
      .mem_wr    (mem_wr),
      .mem_wdata (mem_wdata),
      .pc_load   (pc_load),
      .pc_addr   (pc_addr),
      .ir        (ir),
      .acc       (acc),
      .zero      (zero),
      .halted    (halted)
   );

   // Queue the four phases of one instruction. a_b/h_b hold during fetch and operand,
   // a_a/h_a from the store phase on; pl/pa are the phase-3 PC request.
   task automatic push_instr(input logic [7:0] p, input logic [7:0] ir_o, input logic [7:0] ir_n,
                             input logic [7:0] a_b, input logic [7:0] a_a, input logic [7:0] opa,
                             input logic rd1, input logic wr2, input logic pl, input logic [7:0] pa,
                             input logic h_b, input logic h_a);
      exp_t e;
      e = '{addr: p, rd: !h_b, wr: 1'b0, wdata: a_b, pl: 1'b0, pa: p, ir: ir_o,
            acc: a_b, zero: (a_b == 8'h00), halted: h_b};
      sb.push_back(e);
      e = '{addr: opa, rd: rd1 && !h_b, wr: 1'b0, wdata: a_b, pl: 1'b0, pa: p, ir: ir_n,
            acc: a_b, zero: (a_b == 8'h00), halted: h_b};
      sb.push_back(e);
      e = '{addr: wr2 ? opa : p, rd: 1'b0, wr: wr2 && !h_a, wdata: a_a, pl: 1'b0, pa: p, ir: ir_n,
            acc: a_a, zero: (a_a == 8'h00), halted: h_a};
      sb.push_back(e);
      e = '{addr: p, rd: 1'b0, wr: 1'b0, wdata: a_a, pl: pl, pa: pa, ir: ir_n,
            acc: a_a, zero: (a_a == 8'h00), halted: h_a};
      sb.push_back(e);
   endtask

   // Drive nph phases at pc=p and compare each against the scoreboard head.
   task automatic run_instr(input logic [7:0] p, input int nph);
      exp_t e;
      for (int u = 0; u < nph; u++) begin
         @(negedge clk);
         pc  = p;
         upc = u[1:0];
         #1;
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL sb_empty pc=%h upc=%0d: no expected entry", p, u);
         end else begin
            e = sb.pop_front();
            if (mem_addr !== e.addr) begin errors++; $display("FAIL mem_addr pc=%h upc=%0d got %h exp %h", p, u, mem_addr, e.addr); end
            checks++;
            if (mem_rd !== e.rd) begin errors++; $display("FAIL mem_rd pc=%h upc=%0d got %b exp %b", p, u, mem_rd, e.rd); end
            checks++;
            if (mem_wr !== e.wr) begin errors++; $display("FAIL mem_wr pc=%h upc=%0d got %b exp %b", p, u, mem_wr, e.wr); end
            checks++;
            if (mem_wdata !== e.wdata) begin errors++; $display("FAIL mem_wdata pc=%h upc=%0d got %h exp %h", p, u, mem_wdata, e.wdata); end
            checks++;
            if (pc_load !== e.pl) begin errors++; $display("FAIL pc_load pc=%h upc=%0d got %b exp %b", p, u, pc_load, e.pl); end
            checks++;
            if (pc_addr !== e.pa) begin errors++; $display("FAIL pc_addr pc=%h upc=%0d got %h exp %h", p, u, pc_addr, e.pa); end
            checks++;
            if (ir !== e.ir) begin errors++; $display("FAIL ir pc=%h upc=%0d got %h exp %h", p, u, ir, e.ir); end
            checks++;
            if (acc !== e.acc) begin errors++; $display("FAIL acc pc=%h upc=%0d got %h exp %h", p, u, acc, e.acc); end
            checks++;
            if (zero !== e.zero) begin errors++; $display("FAIL zero pc=%h upc=%0d got %b exp %b", p, u, zero, e.zero); end
            checks++;
            if (halted !== e.halted) begin errors++; $display("FAIL halted pc=%h upc=%0d got %b exp %b", p, u, halted, e.halted); end
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      pc  = 8'h00;
      upc = 2'd0;
      #2;
      checks++; if (ir !== 8'h00)    begin errors++; $display("FAIL reset_ir got %h exp 00", ir); end
      checks++; if (acc !== 8'h00)   begin errors++; $display("FAIL reset_acc got %h exp 00", acc); end
      checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %b exp 0", halted); end
      checks++; if (zero !== 1'b1)   begin errors++; $display("FAIL reset_zero got %b exp 1", zero); end
      checks++; if (mem_rd !== 1'b1) begin errors++; $display("FAIL reset_fetch_rd got %b exp 1", mem_rd); end
      checks++; if (mem_wr !== 1'b0 || pc_load !== 1'b0) begin
         errors++; $display("FAIL reset_strobes got wr=%b pl=%b exp 0 0", mem_wr, pc_load);
      end
      // Idle in phase 3 across reset release so no fetch happens before the first test.
      upc = 2'd3;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_arith();
      mem[8'h00] = 8'hA5; mem[8'h05] = 8'h3C;
      mem[8'h01] = 8'h46; mem[8'h06] = 8'hC8;
      push_instr(8'h00, 8'h00, 8'hA5, 8'h00, 8'h3C, 8'h05, 1, 0, 0, 8'h00, 0, 0);
      run_instr(8'h00, 4);
      push_instr(8'h01, 8'hA5, 8'h46, 8'h3C, 8'h04, 8'h06, 1, 0, 0, 8'h01, 0, 0);
      run_instr(8'h01, 4);
   endtask

   task automatic test_store();
      mem[8'h02] = 8'hC7;
      push_instr(8'h02, 8'h46, 8'hC7, 8'h04, 8'h04, 8'h07, 0, 1, 0, 8'h02, 0, 0);
      run_instr(8'h02, 4);
   endtask

   task automatic test_skip();
      mem[8'h03] = 8'h88; mem[8'h08] = 8'h04;
      mem[8'h0A] = 8'h20;
      mem[8'h0C] = 8'hA9; mem[8'h09] = 8'h01;
      mem[8'h0D] = 8'h20;
      mem[8'h0E] = 8'hB0; mem[8'h10] = 8'h00;
      mem[8'hFF] = 8'h20;
      push_instr(8'h03, 8'hC7, 8'h88, 8'h04, 8'h00, 8'h08, 1, 0, 0, 8'h03, 0, 0);
      run_instr(8'h03, 4);
      push_instr(8'h0A, 8'h88, 8'h20, 8'h00, 8'h00, 8'h00, 0, 0, 1, 8'h0C, 0, 0);
      run_instr(8'h0A, 4);
      push_instr(8'h0C, 8'h20, 8'hA9, 8'h00, 8'h01, 8'h09, 1, 0, 0, 8'h0C, 0, 0);
      run_instr(8'h0C, 4);
      push_instr(8'h0D, 8'hA9, 8'h20, 8'h01, 8'h01, 8'h00, 0, 0, 0, 8'h0D, 0, 0);
      run_instr(8'h0D, 4);
      push_instr(8'h0E, 8'h20, 8'hB0, 8'h01, 8'h00, 8'h10, 1, 0, 0, 8'h0E, 0, 0);
      run_instr(8'h0E, 4);
      push_instr(8'hFF, 8'hB0, 8'h20, 8'h00, 8'h00, 8'h00, 0, 0, 1, 8'h01, 0, 0);
      run_instr(8'hFF, 4);
   endtask

   task automatic test_jump();
      mem[8'h30] = 8'hF3;
      mem[8'h13] = 8'hA9;
      push_instr(8'h30, 8'h20, 8'hF3, 8'h00, 8'h00, 8'h13, 0, 0, 1, 8'h13, 0, 0);
      run_instr(8'h30, 4);
      push_instr(8'h13, 8'hF3, 8'hA9, 8'h00, 8'h01, 8'h09, 1, 0, 0, 8'h13, 0, 0);
      run_instr(8'h13, 4);
   endtask

   task automatic test_halt();
      mem[8'h20] = 8'h00;
      push_instr(8'h20, 8'hA9, 8'h00, 8'h01, 8'h01, 8'h00, 0, 0, 1, 8'h20, 0, 1);
      run_instr(8'h20, 4);
      // A non-HLT word at the frozen PC exposes any fetch that leaks through the halt.
      mem[8'h20] = 8'hA5;
      for (int i = 0; i < 5; i++) begin
         push_instr(8'h20, 8'h00, 8'h00, 8'h01, 8'h01, 8'h00, 0, 0, 1, 8'h20, 1, 1);
         run_instr(8'h20, 4);
      end
      @(negedge clk);
      rst = 1'b1;
      #1;
      checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halt_rst_halted got %b exp 0", halted); end
      checks++; if (acc !== 8'h00)   begin errors++; $display("FAIL halt_rst_acc got %h exp 00", acc); end
      checks++; if (ir !== 8'h00)    begin errors++; $display("FAIL halt_rst_ir got %h exp 00", ir); end
      upc = 2'd3;
      #1;
      rst = 1'b0;
   endtask

   task automatic test_reset_mid();
      mem[8'h40] = 8'hA5;
      mem[8'h41] = 8'hC7;
      push_instr(8'h40, 8'h00, 8'hA5, 8'h00, 8'h3C, 8'h05, 1, 0, 0, 8'h40, 0, 0);
      run_instr(8'h40, 4);
      push_instr(8'h41, 8'hA5, 8'hC7, 8'h3C, 8'h3C, 8'h07, 0, 1, 0, 8'h41, 0, 0);
      run_instr(8'h41, 3);
      void'(sb.pop_back());
      rst = 1'b1;
      #1;
      checks++; if (mem_wr !== 1'b0) begin errors++; $display("FAIL mid_rst_wr got %b exp 0", mem_wr); end
      checks++; if (acc !== 8'h00)   begin errors++; $display("FAIL mid_rst_acc got %h exp 00", acc); end
      checks++; if (ir !== 8'h00)    begin errors++; $display("FAIL mid_rst_ir got %h exp 00", ir); end
      checks++; if (halted !== 1'b0) begin errors++; $display("FAIL mid_rst_halted got %b exp 0", halted); end
      pc  = 8'h00;
      upc = 2'd0;
      #1;
      rst = 1'b0;
      #1;
      checks++; if (mem_addr !== 8'h00) begin errors++; $display("FAIL mid_rst_fetch_addr got %h exp 00", mem_addr); end
      checks++; if (mem_rd !== 1'b1)    begin errors++; $display("FAIL mid_rst_fetch_rd got %b exp 1", mem_rd); end
      @(posedge clk);
      #1;
      checks++; if (ir !== 8'hA5) begin errors++; $display("FAIL mid_rst_refetch_ir got %h exp a5", ir); end
      checks++; if (sb.size() != 0) begin errors++; $display("FAIL sb_leftover got %0d entries exp 0", sb.size()); end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      test_reset();
      test_arith();
      test_store();
      test_skip();
      test_jump();
      test_halt();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
